// File: rtl/pipe_ctrl.sv
// pipe_ctrl: redirect, stall and flush control for the PC, IF/ID and ID/EX registers.
// The bus-stall watchdog is built only when PIPE_CTRL_TIMEOUT_EN is defined.
module pipe_ctrl #(
  parameter int FLUSH_CYCLES = 1,
  parameter int TIMEOUT      = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        jump_flag_i,
  input  logic [31:0] jump_addr_i,
  input  logic        hold_bus_i,
  input  logic        hold_ex_i,
  output logic        jump_o,
  output logic [31:0] jump_addr_o,
  output logic        stall_pc_o,
  output logic        stall_if_id_o,
  output logic        flush_if_id_o,
  output logic        flush_id_ex_o,
  output logic        bus_err_o
);

  localparam logic [1:0] ST_RUN      = 2'd0;
  localparam logic [1:0] ST_FLUSH    = 2'd1;
  localparam logic [1:0] ST_BUS_WAIT = 2'd2;

  localparam logic [1:0] FLUSH_RELOAD = 2'(FLUSH_CYCLES - 1);
  localparam bit         MULTI_FLUSH  = (FLUSH_CYCLES > 1);

  generate
    if (FLUSH_CYCLES < 1 || FLUSH_CYCLES > 4) begin : g_bad_flush
      $error("pipe_ctrl: FLUSH_CYCLES must be in 1..4");
    end
    if (TIMEOUT < 1 || TIMEOUT > 65535) begin : g_bad_timeout
      $error("pipe_ctrl: TIMEOUT must be in 1..65535");
    end
  endgenerate

  logic [1:0]  state, state_next;
  logic [1:0]  flush_cnt, flush_cnt_next;
  logic        pend_vld, pend_vld_next;
  logic [31:0] pend_addr, pend_addr_next;

  logic        use_pend;
  logic        issue;
  logic [31:0] issue_addr;
  logic        ex_stall;
  logic        flushing;

  // Decision flags encode the priority bus stall > jump (pending first) > EX stall.
  always_comb begin
    use_pend   = (state == ST_BUS_WAIT) && pend_vld;
    issue      = !hold_bus_i && (use_pend || jump_flag_i);
    issue_addr = use_pend ? pend_addr : jump_addr_i;
    // EX only carries bubbles while a flush drains, so hold_ex_i is not honoured then.
    ex_stall   = !hold_bus_i && !issue && hold_ex_i && (state != ST_FLUSH);
    flushing   = !hold_bus_i && !issue && (state == ST_FLUSH);
  end

  always_comb begin
    jump_o        = 1'b0;
    jump_addr_o   = 32'h0;
    stall_pc_o    = 1'b0;
    stall_if_id_o = 1'b0;
    flush_if_id_o = 1'b0;
    flush_id_ex_o = 1'b0;
    if (rst) begin
      stall_pc_o    = 1'b1;
      flush_if_id_o = 1'b1;
      flush_id_ex_o = 1'b1;
    end else begin
      jump_o        = issue;
      jump_addr_o   = issue ? issue_addr : 32'h0;
      stall_pc_o    = hold_bus_i | ex_stall;
      stall_if_id_o = hold_bus_i | ex_stall;
      flush_if_id_o = issue | flushing;
      flush_id_ex_o = hold_bus_i | ex_stall | issue | flushing;
    end
  end

  always_comb begin
    state_next     = state;
    flush_cnt_next = flush_cnt;
    pend_vld_next  = pend_vld;
    pend_addr_next = pend_addr;
    if (hold_bus_i) begin
      // A bus stall abandons any flush; a jump seen now is parked for replay.
      state_next     = ST_BUS_WAIT;
      flush_cnt_next = 2'd0;
      if (jump_flag_i) begin
        pend_vld_next  = 1'b1;
        pend_addr_next = jump_addr_i;
      end
    end else if (issue) begin
      if (use_pend) begin
        pend_vld_next = 1'b0;
      end
      if (MULTI_FLUSH) begin
        state_next     = ST_FLUSH;
        flush_cnt_next = FLUSH_RELOAD;
      end else begin
        state_next     = ST_RUN;
        flush_cnt_next = 2'd0;
      end
    end else if (flushing) begin
      flush_cnt_next = flush_cnt - 2'd1;
      state_next     = (flush_cnt <= 2'd1) ? ST_RUN : ST_FLUSH;
    end else begin
      state_next = ST_RUN;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_RUN;
      flush_cnt <= 2'd0;
      pend_vld  <= 1'b0;
      pend_addr <= 32'h0;
    end else begin
      state     <= state_next;
      flush_cnt <= flush_cnt_next;
      pend_vld  <= pend_vld_next;
      pend_addr <= pend_addr_next;
    end
  end

`ifdef PIPE_CTRL_TIMEOUT_EN
  localparam logic [15:0] TO_MAX = 16'(TIMEOUT);

  logic [15:0] to_cnt;
  logic        bus_err_reg;

  // The pulse is raised on the edge where to_cnt lands on TO_MAX, so saturation blocks repeats.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      to_cnt      <= 16'd0;
      bus_err_reg <= 1'b0;
    end else if (!hold_bus_i) begin
      to_cnt      <= 16'd0;
      bus_err_reg <= 1'b0;
    end else begin
      if (to_cnt != TO_MAX) begin
        to_cnt <= to_cnt + 16'd1;
      end
      bus_err_reg <= (to_cnt == TO_MAX - 16'd1);
    end
  end

  assign bus_err_o = bus_err_reg;
`else
  assign bus_err_o = 1'b0;
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed bench for pipe_ctrl: two instances (FLUSH_CYCLES 2 and 3, TIMEOUT 10) share one stimulus.
// Output vectors are packed {jump, stall_pc, stall_if_id, flush_if_id, flush_id_ex, bus_err}.
module tb_pipe_ctrl;

  localparam logic [5:0] IDLE = 6'b000000;
  localparam logic [5:0] JMP  = 6'b100110;
  localparam logic [5:0] FLS  = 6'b000110;
  localparam logic [5:0] STL  = 6'b011010;
  localparam logic [5:0] RSTV = 6'b010110;

`ifdef PIPE_CTRL_TIMEOUT_EN
  localparam bit WD_EN = 1'b1;
`else
  localparam bit WD_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        jump_flag;
  logic [31:0] jump_addr;
  logic        hold_bus;
  logic        hold_ex;

  logic        f2_jump, f2_stall_pc, f2_stall_if_id, f2_flush_if_id, f2_flush_id_ex, f2_bus_err;
  logic [31:0] f2_addr;
  logic        f3_jump, f3_stall_pc, f3_stall_if_id, f3_flush_if_id, f3_flush_id_ex, f3_bus_err;
  logic [31:0] f3_addr;

  logic [5:0] o2, o3;
  assign o2 = {f2_jump, f2_stall_pc, f2_stall_if_id, f2_flush_if_id, f2_flush_id_ex, f2_bus_err};
  assign o3 = {f3_jump, f3_stall_pc, f3_stall_if_id, f3_flush_if_id, f3_flush_id_ex, f3_bus_err};

  int vectors     = 0;
  int miscompares = 0;

  logic        s_jf [24];
  logic [31:0] s_ja [24];
  logic        s_hb [24];
  logic        s_hx [24];
  logic [5:0]  x2 [24];
  logic [5:0]  x3 [24];
  logic [31:0] y2 [24];
  logic [31:0] y3 [24];

  always #5 clk = ~clk;

  pipe_ctrl #(.FLUSH_CYCLES(2), .TIMEOUT(10)) u_f2 (
    .clk(clk), .rst(rst),
    .jump_flag_i(jump_flag), .jump_addr_i(jump_addr),
    .hold_bus_i(hold_bus), .hold_ex_i(hold_ex),
    .jump_o(f2_jump), .jump_addr_o(f2_addr),
    .stall_pc_o(f2_stall_pc), .stall_if_id_o(f2_stall_if_id),
    .flush_if_id_o(f2_flush_if_id), .flush_id_ex_o(f2_flush_id_ex),
    .bus_err_o(f2_bus_err)
  );

  pipe_ctrl #(.FLUSH_CYCLES(3), .TIMEOUT(10)) u_f3 (
    .clk(clk), .rst(rst),
    .jump_flag_i(jump_flag), .jump_addr_i(jump_addr),
    .hold_bus_i(hold_bus), .hold_ex_i(hold_ex),
    .jump_o(f3_jump), .jump_addr_o(f3_addr),
    .stall_pc_o(f3_stall_pc), .stall_if_id_o(f3_stall_if_id),
    .flush_if_id_o(f3_flush_if_id), .flush_id_ex_o(f3_flush_id_ex),
    .bus_err_o(f3_bus_err)
  );

  // Drive one cycle of inputs and move to the sampling point.
  task automatic step(input logic jf, input logic [31:0] ja, input logic hb, input logic hx);
    jump_flag = jf;
    jump_addr = ja;
    hold_bus  = hb;
    hold_ex   = hx;
    @(negedge clk);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_tables();
    for (int i = 0; i < 24; i++) begin
      s_jf[i] = 1'b0; s_ja[i] = 32'h0; s_hb[i] = 1'b0; s_hx[i] = 1'b0;
      x2[i] = IDLE; x3[i] = IDLE; y2[i] = 32'h0; y3[i] = 32'h0;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    jump_flag = 1'b0; jump_addr = 32'h0; hold_bus = 1'b0; hold_ex = 1'b0;
    @(negedge clk);
    vectors++;
    if (o2 !== RSTV || f2_addr !== 32'h0) begin
      miscompares++;
      $display("FAIL reset f2: got %b addr %h, expected %b addr %h", o2, f2_addr, RSTV, 32'h0);
    end
    vectors++;
    if (o3 !== RSTV || f3_addr !== 32'h0) begin
      miscompares++;
      $display("FAIL reset f3: got %b addr %h, expected %b addr %h", o3, f3_addr, RSTV, 32'h0);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    step(1'b0, 32'h0, 1'b0, 1'b0);
    vectors++;
    if (o2 !== IDLE || o3 !== IDLE) begin
      miscompares++;
      $display("FAIL reset_release: got f2 %b f3 %b, expected %b", o2, o3, IDLE);
    end
    tick();
    $display("test_reset done");
  endtask

  task automatic test_jump();
    clear_tables();
    s_jf[0] = 1'b1; s_ja[0] = 32'h0000_0100;
    x2[0] = JMP; y2[0] = 32'h100; x2[1] = FLS;
    x3[0] = JMP; y3[0] = 32'h100; x3[1] = FLS; x3[2] = FLS;
    for (int c = 0; c < 4; c++) begin
      step(s_jf[c], s_ja[c], s_hb[c], s_hx[c]);
      vectors++;
      if (o2 !== x2[c] || f2_addr !== y2[c]) begin
        miscompares++;
        $display("FAIL jump f2 c%0d: got %b addr %h, expected %b addr %h", c, o2, f2_addr, x2[c], y2[c]);
      end
      vectors++;
      if (o3 !== x3[c] || f3_addr !== y3[c]) begin
        miscompares++;
        $display("FAIL jump f3 c%0d: got %b addr %h, expected %b addr %h", c, o3, f3_addr, x3[c], y3[c]);
      end
      tick();
    end
    $display("test_jump done");
  endtask

  task automatic test_reset_mid_flush();
    step(1'b1, 32'h40, 1'b0, 1'b0);
    vectors++;
    if (o3 !== JMP || f3_addr !== 32'h40) begin
      miscompares++;
      $display("FAIL midflush_jump f3: got %b addr %h, expected %b addr %h", o3, f3_addr, JMP, 32'h40);
    end
    tick();
    step(1'b0, 32'h0, 1'b0, 1'b0);
    vectors++;
    if (o3 !== FLS) begin
      miscompares++;
      $display("FAIL midflush_flush f3: got %b, expected %b", o3, FLS);
    end
    rst = 1'b1;
    #1;
    vectors++;
    if (o3 !== RSTV || f3_addr !== 32'h0 || o2 !== RSTV) begin
      miscompares++;
      $display("FAIL midflush_rst: got f3 %b addr %h f2 %b, expected %b addr 0", o3, f3_addr, o2, RSTV);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    step(1'b0, 32'h0, 1'b0, 1'b0);
    vectors++;
    if (o3 !== IDLE || o2 !== IDLE) begin
      miscompares++;
      $display("FAIL midflush_release: got f3 %b f2 %b, expected %b", o3, o2, IDLE);
    end
    tick();
    clear_tables();
    s_jf[0] = 1'b1; s_ja[0] = 32'h80;
    x3[0] = JMP; y3[0] = 32'h80; x3[1] = FLS; x3[2] = FLS;
    x2[0] = JMP; y2[0] = 32'h80; x2[1] = FLS;
    for (int c = 0; c < 4; c++) begin
      step(s_jf[c], s_ja[c], s_hb[c], s_hx[c]);
      vectors++;
      if (o3 !== x3[c] || f3_addr !== y3[c]) begin
        miscompares++;
        $display("FAIL midflush_rejump f3 c%0d: got %b addr %h, expected %b addr %h", c, o3, f3_addr, x3[c], y3[c]);
      end
      vectors++;
      if (o2 !== x2[c] || f2_addr !== y2[c]) begin
        miscompares++;
        $display("FAIL midflush_rejump f2 c%0d: got %b addr %h, expected %b addr %h", c, o2, f2_addr, x2[c], y2[c]);
      end
      tick();
    end
    $display("test_reset_mid_flush done");
  endtask

  task automatic test_bus_pending();
    clear_tables();
    for (int i = 0; i < 5; i++) begin
      s_hb[i] = 1'b1; x2[i] = STL; x3[i] = STL;
    end
    s_jf[2] = 1'b1; s_ja[2] = 32'h200;
    x2[5] = JMP; y2[5] = 32'h200; x2[6] = FLS;
    x3[5] = JMP; y3[5] = 32'h200; x3[6] = FLS; x3[7] = FLS;
    for (int c = 0; c < 9; c++) begin
      step(s_jf[c], s_ja[c], s_hb[c], s_hx[c]);
      vectors++;
      if (o2 !== x2[c] || f2_addr !== y2[c]) begin
        miscompares++;
        $display("FAIL bus_pending f2 c%0d: got %b addr %h, expected %b addr %h", c, o2, f2_addr, x2[c], y2[c]);
      end
      vectors++;
      if (o3 !== x3[c] || f3_addr !== y3[c]) begin
        miscompares++;
        $display("FAIL bus_pending f3 c%0d: got %b addr %h, expected %b addr %h", c, o3, f3_addr, x3[c], y3[c]);
      end
      tick();
    end
    $display("test_bus_pending done");
  endtask

  task automatic test_pend_overwrite();
    clear_tables();
    for (int i = 0; i < 4; i++) begin
      s_hb[i] = 1'b1; x2[i] = STL; x3[i] = STL;
    end
    s_jf[1] = 1'b1; s_ja[1] = 32'h500;
    s_jf[2] = 1'b1; s_ja[2] = 32'h600;
    x2[4] = JMP; y2[4] = 32'h600; x2[5] = FLS;
    x3[4] = JMP; y3[4] = 32'h600; x3[5] = FLS; x3[6] = FLS;
    for (int c = 0; c < 8; c++) begin
      step(s_jf[c], s_ja[c], s_hb[c], s_hx[c]);
      vectors++;
      if (o2 !== x2[c] || f2_addr !== y2[c]) begin
        miscompares++;
        $display("FAIL pend_overwrite f2 c%0d: got %b addr %h, expected %b addr %h", c, o2, f2_addr, x2[c], y2[c]);
      end
      vectors++;
      if (o3 !== x3[c] || f3_addr !== y3[c]) begin
        miscompares++;
        $display("FAIL pend_overwrite f3 c%0d: got %b addr %h, expected %b addr %h", c, o3, f3_addr, x3[c], y3[c]);
      end
      tick();
    end
    $display("test_pend_overwrite done");
  endtask

  task automatic test_simultaneous();
    clear_tables();
    s_jf[0] = 1'b1; s_ja[0] = 32'h300; s_hx[0] = 1'b1;
    s_jf[3] = 1'b1; s_ja[3] = 32'h3A0; s_hb[3] = 1'b1;
    x2[0] = JMP; y2[0] = 32'h300; x2[1] = FLS; x2[3] = STL;
    x2[4] = JMP; y2[4] = 32'h3A0; x2[5] = FLS;
    x3[0] = JMP; y3[0] = 32'h300; x3[1] = FLS; x3[2] = FLS; x3[3] = STL;
    x3[4] = JMP; y3[4] = 32'h3A0; x3[5] = FLS; x3[6] = FLS;
    for (int c = 0; c < 8; c++) begin
      step(s_jf[c], s_ja[c], s_hb[c], s_hx[c]);
      vectors++;
      if (o2 !== x2[c] || f2_addr !== y2[c]) begin
        miscompares++;
        $display("FAIL simultaneous f2 c%0d: got %b addr %h, expected %b addr %h", c, o2, f2_addr, x2[c], y2[c]);
      end
      vectors++;
      if (o3 !== x3[c] || f3_addr !== y3[c]) begin
        miscompares++;
        $display("FAIL simultaneous f3 c%0d: got %b addr %h, expected %b addr %h", c, o3, f3_addr, x3[c], y3[c]);
      end
      tick();
    end
    $display("test_simultaneous done");
  endtask

  task automatic test_hold_ex();
    clear_tables();
    for (int i = 0; i < 4; i++) begin
      s_hx[i] = 1'b1; x2[i] = STL; x3[i] = STL;
    end
    for (int c = 0; c < 5; c++) begin
      step(s_jf[c], s_ja[c], s_hb[c], s_hx[c]);
      vectors++;
      if (o2 !== x2[c] || f2_addr !== y2[c]) begin
        miscompares++;
        $display("FAIL hold_ex f2 c%0d: got %b addr %h, expected %b addr %h", c, o2, f2_addr, x2[c], y2[c]);
      end
      vectors++;
      if (o3 !== x3[c] || f3_addr !== y3[c]) begin
        miscompares++;
        $display("FAIL hold_ex f3 c%0d: got %b addr %h, expected %b addr %h", c, o3, f3_addr, x3[c], y3[c]);
      end
      tick();
    end
    $display("test_hold_ex done");
  endtask

  task automatic test_back_to_back();
    clear_tables();
    s_jf[0] = 1'b1; s_ja[0] = 32'h10;
    s_jf[1] = 1'b1; s_ja[1] = 32'h20;
    s_jf[5] = 1'b1; s_ja[5] = 32'h30;
    s_hb[6] = 1'b1;
    x2[0] = JMP; y2[0] = 32'h10; x2[1] = JMP; y2[1] = 32'h20; x2[2] = FLS;
    x2[5] = JMP; y2[5] = 32'h30; x2[6] = STL;
    x3[0] = JMP; y3[0] = 32'h10; x3[1] = JMP; y3[1] = 32'h20; x3[2] = FLS; x3[3] = FLS;
    x3[5] = JMP; y3[5] = 32'h30; x3[6] = STL;
    for (int c = 0; c < 9; c++) begin
      step(s_jf[c], s_ja[c], s_hb[c], s_hx[c]);
      vectors++;
      if (o2 !== x2[c] || f2_addr !== y2[c]) begin
        miscompares++;
        $display("FAIL back_to_back f2 c%0d: got %b addr %h, expected %b addr %h", c, o2, f2_addr, x2[c], y2[c]);
      end
      vectors++;
      if (o3 !== x3[c] || f3_addr !== y3[c]) begin
        miscompares++;
        $display("FAIL back_to_back f3 c%0d: got %b addr %h, expected %b addr %h", c, o3, f3_addr, x3[c], y3[c]);
      end
      tick();
    end
    $display("test_back_to_back done");
  endtask

  task automatic test_watchdog();
    logic exp_err;
    for (int c = 0; c < 21; c++) begin
      step(1'b0, 32'h0, (c < 20), 1'b0);
      exp_err = WD_EN && (c == 10);
      vectors++;
      if (f2_bus_err !== exp_err || f3_bus_err !== exp_err) begin
        miscompares++;
        $display("FAIL watchdog_long c%0d: got f2 %b f3 %b, expected %b", c, f2_bus_err, f3_bus_err, exp_err);
      end
      tick();
    end
    for (int c = 0; c < 12; c++) begin
      step(1'b0, 32'h0, (c < 10), 1'b0);
      exp_err = WD_EN && (c == 10);
      vectors++;
      if (f2_bus_err !== exp_err || f3_bus_err !== exp_err) begin
        miscompares++;
        $display("FAIL watchdog_restall c%0d: got f2 %b f3 %b, expected %b", c, f2_bus_err, f3_bus_err, exp_err);
      end
      tick();
    end
    $display("test_watchdog done");
  endtask

  initial begin
    test_reset();
    test_jump();
    test_reset_mid_flush();
    test_bus_pending();
    test_pend_overwrite();
    test_simultaneous();
    test_hold_ex();
    test_back_to_back();
    test_watchdog();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL sim_timeout: bench still running at %0t, expected completion earlier", $time);
    $fatal(1, "simulation time limit");
  end

endmodule
